// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch-stage state encoding and default bus widths shared by the fetch unit files
package cpu_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_INSTR_W = 24;
  typedef enum logic [1:0] {S_REQ, S_FULL, S_WAIT, S_DRAIN} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory request/valid bus; the fetch unit is master
interface instr_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);
  logic mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic mem_valid;
  modport master(output mem_req, mem_addr, input mem_rdata, mem_valid);
  modport slave(input mem_req, mem_addr, output mem_rdata, mem_valid);
endinterface

// File: rtl/instr_fetch_unit_fetch_buf.sv
// fetch_buf: one-word fetch buffer tagged with its address; hits when the tag matches the PC
module fetch_buf
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_clr,
  input  logic [INSTR_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_pc,
  output logic o_hit,
  output logic [INSTR_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr
);
  logic r_valid;
  logic [INSTR_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_addr <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data <= i_data;
      r_addr <= i_addr;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end
  assign o_hit = r_valid && r_addr == i_pc;
  assign o_data = r_data;
  assign o_addr = r_addr;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR fetch stage with a one-word buffer and stall on IR miss.
// Define INSTR_FETCH_PREFETCH_EN to fetch buf_addr+1 as soon as the buffer is consumed.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic PCWrite,
  input  logic IRWrite,
  input  logic [ADDR_W-1:0] pc_next,
  instr_fetch_unit_if.master mem,
  output logic [INSTR_W-1:0] IRout,
  output logic [ADDR_W-1:0] pc,
  output logic ir_valid,
  output logic fetch_stall
);
  fetch_state_t r_state, w_state_n;
  logic [ADDR_W-1:0] r_fetch_addr, r_drain_addr, w_fetch_addr_n, w_buf_addr, w_target;
  logic [INSTR_W-1:0] w_buf_data;
  logic w_hit, w_ir_load, w_has_target, w_flush, w_buf_load, w_buf_clr, w_enter_drain;

  fetch_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_buf (
    .clk, .reset,
    .i_load(w_buf_load), .i_clr(w_buf_clr),
    .i_data(mem.mem_rdata), .i_addr(r_fetch_addr), .i_pc(pc),
    .o_hit(w_hit), .o_data(w_buf_data), .o_addr(w_buf_addr)
  );

  assign w_ir_load = IRWrite && w_hit;
  assign fetch_stall = IRWrite && !w_hit;
`ifdef INSTR_FETCH_PREFETCH_EN
  assign w_has_target = 1'b1;
  assign w_target = w_ir_load ? w_buf_addr + ADDR_W'(1) : r_fetch_addr;
`else
  assign w_has_target = !w_ir_load;
  assign w_target = r_fetch_addr;
`endif
  // a PCWrite that leaves the fetch target unchanged is sequential flow, not a flush
  assign w_flush = PCWrite && (!w_has_target || pc_next != w_target);
  assign w_fetch_addr_n = w_flush ? pc_next : w_target;
  assign w_enter_drain = r_state == S_REQ && w_flush && !mem.mem_valid;
  assign w_buf_load = r_state == S_REQ && mem.mem_valid && !w_flush;
  assign w_buf_clr = w_ir_load || w_flush;
  assign mem.mem_req = !reset && (r_state == S_REQ || r_state == S_DRAIN);
  assign mem.mem_addr = r_state == S_DRAIN ? r_drain_addr : r_fetch_addr;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_REQ:   w_state_n = mem.mem_valid ? (w_flush ? S_REQ : S_FULL) : (w_flush ? S_DRAIN : S_REQ);
      S_DRAIN: w_state_n = mem.mem_valid ? S_REQ : S_DRAIN;
      S_FULL:  w_state_n = (w_ir_load && w_has_target) || w_flush ? S_REQ : (w_ir_load ? S_WAIT : S_FULL);
      S_WAIT:  w_state_n = PCWrite ? S_REQ : S_WAIT;
      default: w_state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_REQ;
      r_fetch_addr <= RESET_PC;
      r_drain_addr <= RESET_PC;
      pc <= RESET_PC;
      IRout <= '0;
      ir_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_fetch_addr <= w_fetch_addr_n;
      if (w_enter_drain) r_drain_addr <= r_fetch_addr;
      if (PCWrite) pc <= pc_next;
      if (w_ir_load) begin
        IRout <= w_buf_data;
        ir_valid <= 1'b1;
      end
    end
  end
endmodule
